// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the pipeline controller and the multiply/divide unit.
// The controller drives the slave inputs; the unit returns busy/done and the HI/LO read port.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [1:0]       hilo_wr;
  logic [1:0]       hilo_disable;
  logic             hilosrc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hilo_rdata;

  modport master (
    output start, op, srca, srcb, hilo_wr, hilo_disable, hilosrc,
    input  busy, done, hilo_rdata
  );

  modport slave (
    input  start, op, srca, srcb, hilo_wr, hilo_disable, hilosrc,
    output busy, done, hilo_rdata
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One radix-2 iteration per cycle, followed by a single sign-fixup cycle that commits HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_isDiv;
  logic               r_divZero;
  logic               r_negXor;
  logic               r_negRem;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_rawA;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_trialOk;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = ~bus.op[0];
  assign w_signA  = w_signed & bus.srca[WIDTH-1];
  assign w_signB  = w_signed & bus.srcb[WIDTH-1];
  assign w_magA   = w_signA ? -bus.srca : bus.srca;
  assign w_magB   = w_signB ? -bus.srcb : bus.srcb;

  // Multiply keeps {partial HI, remaining multiplier} in r_acc; divide keeps {remainder, dividend/quotient}.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_operand};
  assign w_trialOk = ~w_trial[WIDTH];

  assign w_prod = r_negXor ? -r_acc : r_acc;
  assign w_quo  = r_negXor ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.hilo_rdata = bus.hilosrc ? r_hi : r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_isDiv   <= 1'b0;
      r_divZero <= 1'b0;
      r_negXor  <= 1'b0;
      r_negRem  <= 1'b0;
      r_count   <= '0;
      r_operand <= '0;
      r_rawA    <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_isDiv   <= bus.op[1];
            r_count   <= '0;
            r_rawA    <= bus.srca;
            r_divZero <= (bus.srcb == '0);
            r_negXor  <= w_signA ^ w_signB;
            r_negRem  <= w_signA;
            if (bus.op[1]) begin
              r_operand <= w_magB;
              r_acc     <= {{WIDTH{1'b0}}, w_magA};
            end else begin
              r_operand <= w_magA;
              r_acc     <= {{WIDTH{1'b0}}, w_magB};
            end
          end else begin
            if (bus.hilo_wr[1] && !bus.hilo_disable[1]) r_hi <= bus.srca;
            if (bus.hilo_wr[0] && !bus.hilo_disable[0]) r_lo <= bus.srca;
          end
        end
        RUN: begin
          r_count <= r_count + CW'(1);
          if (r_isDiv) begin
            r_acc <= {(w_trialOk ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_trialOk};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
          if (r_count == CW'(WIDTH-1)) r_state <= FIXUP;
        end
        FIXUP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          // Divide by zero reports the raw dividend untouched by any sign fixup.
          if (!r_isDiv) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_divZero) begin
            r_lo <= '1;
            r_hi <= r_rawA;
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
